// File: rtl/instr_fetch_decode_pkg.sv
// instr_fetch_decode_pkg: shared opcode constants, field ranges, FSM states and decoded-op type
package instr_fetch_decode_pkg;
  localparam logic [7:0] OP_NOP = 8'd0;
  localparam logic [7:0] OP_ADDIM = 8'd1;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 24;
  localparam int IMM_W = 24;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
  typedef struct packed {
    logic [7:0] opc;
    logic [IMM_W-1:0] imm;
    logic [31:0] pc;
    logic ill;
  } op_t;
endpackage

// File: rtl/decode_fifo.sv
// decode_fifo: small FIFO of decoded ops with synchronous clear; head reads as zero when empty
module decode_fifo
  import instr_fetch_decode_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  op_t                      din,
  output op_t                      head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  op_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic full, wr, rd;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr = push && !full && !clear;
  assign rd = pop && !empty && !clear;
  assign head = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + CW'(wr) - CW'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: fetch FSM owning the PC, opcode/operand decode, and op issue to the ALU
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int          DEPTH      = 2,
  parameter logic [31:0] RESET_ADDR = 32'd0,
  parameter logic [31:0] ADDR_STEP  = 32'd1,
  parameter logic [7:0]  MAX_OPCODE = 8'd63
) (
  input  logic        Clk,
  input  logic        Rst_n,
  output logic        InstrReq,
  output logic [31:0] InstrAddr,
  input  logic [31:0] InstrData,
  input  logic        InstrValid,
  input  logic        Flush,
  input  logic [31:0] FlushAddr,
  output logic        OpValid,
  input  logic        OpAccept,
  output logic [7:0]  ALU_Sel,
  output logic [23:0] DecoderData,
  output logic [31:0] OpPC,
  output logic        OpIllegal
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state;
  logic [31:0] pc;
  logic [CW-1:0] count;
  logic empty, push, ill;
  logic [7:0] opc;
  op_t din, head;
  assign opc = InstrData[OPC_MSB:OPC_LSB];
  assign ill = opc > MAX_OPCODE;
  assign din = '{opc: ill ? OP_NOP : opc, imm: ill ? '0 : InstrData[IMM_W-1:0], pc: pc, ill: ill};
  assign push = state == WAIT && InstrValid && !Flush;
  decode_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(Clk),
    .rst_n(Rst_n),
    .clear(Flush),
    .push(push),
    .pop(OpAccept),
    .din(din),
    .head(head),
    .count(count),
    .empty(empty)
  );
  assign OpValid = !empty;
  assign ALU_Sel = head.opc;
  assign DecoderData = head.imm;
  assign OpPC = head.pc;
  assign OpIllegal = head.ill;
  // A request already on the bus when Flush hits must still be answered, so it is drained in DROP
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state <= IDLE;
      pc <= RESET_ADDR;
      InstrReq <= 1'b0;
      InstrAddr <= '0;
    end else begin
      InstrReq <= 1'b0;
      InstrAddr <= '0;
      case (state)
        IDLE: if (!Flush && count < CW'(DEPTH)) begin
          state <= REQ;
          InstrReq <= 1'b1;
          InstrAddr <= pc;
        end
        REQ: state <= Flush ? DROP : WAIT;
        WAIT: if (Flush) state <= InstrValid ? IDLE : DROP;
              else if (InstrValid) state <= IDLE;
        DROP: if (InstrValid) state <= IDLE;
      endcase
      if (Flush) pc <= FlushAddr;
      else if (push) pc <= pc + ADDR_STEP;
    end
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: directed + random checks of fetch/decode against a program-order op model
module tb_instr_fetch_decode;
  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        InstrReq;
  logic [31:0] InstrAddr;
  logic [31:0] InstrData;
  logic        InstrValid;
  logic        Flush;
  logic [31:0] FlushAddr;
  logic        OpValid;
  logic        OpAccept;
  logic [7:0]  ALU_Sel;
  logic [23:0] DecoderData;
  logic [31:0] OpPC;
  logic        OpIllegal;

  instr_fetch_decode dut (
    .Clk(Clk), .Rst_n(Rst_n), .InstrReq(InstrReq), .InstrAddr(InstrAddr),
    .InstrData(InstrData), .InstrValid(InstrValid), .Flush(Flush), .FlushAddr(FlushAddr),
    .OpValid(OpValid), .OpAccept(OpAccept), .ALU_Sel(ALU_Sel), .DecoderData(DecoderData),
    .OpPC(OpPC), .OpIllegal(OpIllegal)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int fixed_lat = 0;
  logic [31:0] salt;
  logic [31:0] exp_pc;
  logic [31:0] req_q[$];
  int n;
  logic r_fl, r_acc;
  logic [31:0] r_fa;

  // Program image: a few fixed words at the bottom, hashed pseudo-random words elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E3779B1) ^ salt;
    case (a)
      32'd0: return 32'h0100_0005;
      32'd1: return 32'h0000_0000;
      32'd2: return 32'hFF12_3456;
      32'd3: return 32'h0200_0003;
      default: return {h[31:24] % 8'd80, h[23:0]};
    endcase
  endfunction

  function automatic logic [31:0] q_at(input int i);
    return i < req_q.size() ? req_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop();
    logic [31:0] w;
    logic [7:0] o;
    w = mem_word(exp_pc);
    o = w[31:24];
    if (o > 8'd63) chk("pop", {ALU_Sel, DecoderData, OpPC, OpIllegal}, {8'd0, 24'd0, exp_pc, 1'b1});
    else chk("pop", {ALU_Sel, DecoderData, OpPC, OpIllegal}, {o, w[23:0], exp_pc, 1'b0});
    exp_pc = exp_pc + 32'd1;
  endtask

  task automatic tick(input logic acc, input logic fl, input logic [31:0] fa);
    OpAccept = acc;
    Flush = fl;
    FlushAddr = fa;
    #1;
    if (InstrReq) req_q.push_back(InstrAddr);
    if (fl) exp_pc = fa;
    else if (OpValid && acc) check_pop();
    @(negedge Clk);
  endtask

  task automatic wait_req(input logic acc);
    int k;
    k = req_q.size();
    for (int i = 0; i < 40 && req_q.size() == k; i++) tick(acc, 1'b0, 32'd0);
    chk("req_seen", 96'(req_q.size() > k), 96'd1);
  endtask

  // Memory controller: answers each request once, 1..3 negedges later unless a fixed latency is set
  initial begin
    logic [31:0] ra;
    int lat;
    InstrValid = 1'b0;
    InstrData = '0;
    forever begin
      @(negedge Clk);
      if (InstrReq) begin
        ra = InstrAddr;
        lat = fixed_lat > 0 ? fixed_lat : int'($urandom_range(1, 3));
        repeat (lat) @(negedge Clk);
        InstrValid = 1'b1;
        InstrData = mem_word(ra);
        @(negedge Clk);
        InstrValid = 1'b0;
        InstrData = '0;
      end
    end
  end

  initial begin
    Rst_n = 1'b0;
    OpAccept = 1'b0;
    Flush = 1'b0;
    FlushAddr = '0;
    salt = $urandom;
    exp_pc = 32'd0;
    @(negedge Clk);
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    chk("reset_fetch", {InstrReq, InstrAddr}, 96'd0);
    chk("reset_op", {OpValid, ALU_Sel, DecoderData, OpPC, OpIllegal}, 96'd0);
    Rst_n = 1'b1;
    // Run with backpressure: two words fill the FIFO, then fetch stops
    repeat (15) tick(1'b0, 1'b0, 32'd0);
    chk("req_count_full", req_q.size(), 96'd2);
    chk("req0_addr", q_at(0), 96'd0);
    chk("req1_addr", q_at(1), 96'd1);
    chk("head0", {OpValid, ALU_Sel, DecoderData, OpPC, OpIllegal}, {1'b1, 8'd1, 24'd5, 32'd0, 1'b0});
    tick(1'b1, 1'b0, 32'd0);
    repeat (10) tick(1'b0, 1'b0, 32'd0);
    chk("one_new_req", req_q.size(), 96'd3);
    chk("req2_addr", q_at(2), 96'd2);
    chk("head1", {OpValid, ALU_Sel, OpPC}, {1'b1, 8'd0, 32'd1});
    tick(1'b1, 1'b0, 32'd0);
    chk("illegal_head", {OpValid, ALU_Sel, DecoderData, OpPC, OpIllegal}, {1'b1, 8'd0, 24'd0, 32'd2, 1'b1});
    tick(1'b1, 1'b0, 32'd0);
    repeat (10) tick(1'b0, 1'b0, 32'd0);
    chk("after_illegal", {OpValid, ALU_Sel, DecoderData, OpPC, OpIllegal}, {1'b1, 8'd2, 24'd3, 32'd3, 1'b0});
    // Flush while waiting for the word: late data dropped, fetch resumes at 0x40
    fixed_lat = 6;
    wait_req(1'b1);
    tick(1'b0, 1'b1, 32'h40);
    chk("flush_wait_opvalid", OpValid, 96'd0);
    fixed_lat = 0;
    n = req_q.size();
    wait_req(1'b0);
    chk("flush_wait_addr", q_at(n), 96'h40);
    repeat (8) tick(1'b0, 1'b0, 32'd0);
    chk("flush_wait_head", {OpValid, OpPC}, {1'b1, 32'h40});
    // Flush coinciding with InstrValid and OpAccept
    tick(1'b1, 1'b0, 32'd0);
    fixed_lat = 2;
    wait_req(1'b0);
    tick(1'b0, 1'b0, 32'd0);
    chk("pre_flush_opvalid", OpValid, 96'd1);
    tick(1'b1, 1'b1, 32'h80);
    chk("flush_same_cycle_opvalid", OpValid, 96'd0);
    fixed_lat = 0;
    n = req_q.size();
    wait_req(1'b0);
    chk("flush_same_cycle_addr", q_at(n), 96'h80);
    // Random traffic, including redirects that wrap the PC past 2^32
    for (int i = 0; i < 400; i++) begin
      r_acc = $urandom_range(0, 3) != 0;
      r_fl = $urandom_range(0, 39) == 0;
      r_fa = $urandom_range(0, 1) ? 32'hFFFF_FFFE : $urandom;
      tick(r_acc, r_fl, r_fa);
    end
    // Asynchronous reset in the middle of a fetch
    fixed_lat = 4;
    wait_req(1'b1);
    #2 Rst_n = 1'b0;
    #1;
    chk("async_reset_fetch", {InstrReq, InstrAddr}, 96'd0);
    chk("async_reset_op", {OpValid, ALU_Sel, DecoderData, OpPC, OpIllegal}, 96'd0);
    exp_pc = 32'd0;
    fixed_lat = 0;
    @(negedge Clk);
    repeat (6) tick(1'b0, 1'b0, 32'd0);
    Rst_n = 1'b1;
    n = req_q.size();
    wait_req(1'b0);
    chk("post_reset_addr", q_at(n), 96'd0);
    repeat (20) tick(1'b1, 1'b0, 32'd0);
    chk("post_reset_progress", 96'(exp_pc > 32'd2), 96'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
